cpu_mem_responder: RTL and testbench
====================================

# cpu_mem_responder

Memory-side responder for the multi-cycle MIPS core's CS/WE/ADDR/Mem_Bus interface. Holds a 128 x 32 word array, answers instruction fetches and lw with same-cycle read data on the shared tri-state bus, and commits sw writes on the clock edge. After reset it first runs a byte-stream program loader. While the loader runs it holds the CPU in reset; when loading completes it releases the CPU and switches to bus-responder mode.

## Interface
- DEPTH, 128, number of 32-bit words; must equal 2^ADDR_W
- ADDR_W, 7, word-address width; matches CPU ADDR
- DATA_W, 32, bus width
- CLK  in  1  single clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- CS  in  1  chip select from CPU
- WE  in  1  write enable from CPU; meaningful only with CS
- ADDR  in  ADDR_W  word address from CPU
- Mem_Bus  inout  DATA_W  shared data bus; driven by this block only for reads
- LD_VALID  in  1  loader byte valid
- LD_BYTE  in  8  loader byte
- LD_LAST  in  1  qualifies the final byte of the image
- LD_READY  out  1  loader byte accepted when LD_VALID & LD_READY at a rising edge
- CPU_HOLD  out  1  drives CPU RST; 1 holds the CPU in reset
- LD_DONE  out  1  image loaded; CPU running
- LD_WORDS  out  ADDR_W+1  count of words written by the loader (0..128)

## Operation
- The FSM has three states: IDLE, LOAD and RUN. Reset forces IDLE.
- IDLE:
  - Outputs: CPU_HOLD=1, LD_READY=0, LD_DONE=0.
  - Unconditionally goes to LOAD on the next edge.
- LOAD:
  - Outputs: CPU_HOLD=1, LD_READY=1.
  - Byte assembly:
    - Accepted bytes are packed big-endian. Byte lane counter 0..3 maps to bits [31:24], [23:16], [15:8], [7:0].
    - When lane 3 is accepted, the full word (held bytes plus the incoming byte) is written to mem[wptr] on that same edge. Then wptr++, LD_WORDS++, and the lane counter returns to 0.
  - LD_LAST:
    - When accepted with a byte in lane k<3, the lanes above k are zero-padded and the word is written on that edge.
    - In every case, LD_LAST causes a transition to RUN on that edge.
    - LD_LAST accepted in lane 0 still writes a word of {byte, 24'h0}.
  - Full: when word 127 is written (LD_WORDS becomes 128), go to RUN on that edge, even without LD_LAST.
  - While in LOAD:
    - CPU CS/WE are ignored.
    - Mem_Bus is high-Z.
- RUN:
  - Outputs: CPU_HOLD=0, LD_DONE=1, LD_READY=0. Loader inputs are ignored.
  - Read (CS=1, WE=0): Mem_Bus = mem[ADDR], combinationally, in the same cycle.
  - Write (CS=1, WE=1): mem[ADDR] <= Mem_Bus at the rising edge. Mem_Bus is high-Z; the CPU drives it.
  - CS=0: Mem_Bus is high-Z and the array is unchanged.
  - RUN is left only by reset.
- The array is not cleared by reset. A reset in mid-load restarts the load at word 0; untouched words keep their old contents.

## Timing
- Reset values (asynchronous):
  - state=IDLE, wptr=0, lane=0, LD_WORDS=0.
  - CPU_HOLD=1, LD_READY=0, LD_DONE=0, Mem_Bus high-Z.
- Read latency is zero cycles. The CPU samples the bus at the edge that ends its CS cycle, so data must be valid before that edge.
- Write is committed at the edge where CS & WE is high. A read of the same address in the next cycle returns the new data.
- Loader throughput is one byte per cycle; there is no back-pressure inside LOAD.
- CPU_HOLD falls on the edge that enters RUN. The CPU performs its first fetch (ADDR=0) one cycle after CPU_HOLD falls.
- Bus contention must never occur. This block drives only when state==RUN & CS & !WE.

## Structure
- The shared package holds:
  - the FSM state encoding: IDLE, LOAD, RUN;
  - the ADDR_W, DATA_W and DEPTH constants;
  - the byte-lane index type.
- One sub-module, byte_word_packer, contains the lane counter, shift/merge, zero-pad and word-valid pulse. The top level contains the FSM, wptr, the array and the bus tri-state.

## Test plan
- Reset, then 8 bytes 01..08 with LD_LAST on 08 -> mem[0]=32'h01020304, mem[1]=32'h05060708, LD_WORDS=2. CPU_HOLD falls on the edge that accepts the last byte.
- 5 bytes AA BB CC DD EE with LD_LAST on EE -> mem[1]=32'hEE000000, LD_WORDS=2, then RUN.
- 512 bytes with no LD_LAST -> RUN entered after word 127 is written, LD_WORDS=128. LD_READY=0 afterwards, and later bytes change nothing.
- RUN: CS=1, WE=1, ADDR=5, bus=32'hDEADBEEF for one cycle, then CS=1, WE=0, ADDR=5 -> Mem_Bus=32'hDEADBEEF in that same cycle. With CS=0 the bus is Z.
- RST_N pulsed low after 6 bytes of a load:
  - Immediately: CPU_HOLD=1, LD_READY=0, LD_WORDS=0.
  - Reloading 4 bytes 11 22 33 44 with LD_LAST on 44 gives mem[0]=32'h11223344; mem[1] keeps its old contents.
- Integration with the MIPS core: load an addi/sw/lw/beq program -> CPU runs it, and the expected words appear in memory. No cycle has both the responder and the CPU driving Mem_Bus.

Source files
------------

// File: rtl/cpu_mem_responder_pkg.sv
// Shared constants and types for the CPU memory responder.
// Holds the FSM state encoding, array geometry and the byte-lane index type.
// No logic; imported by the responder top and its byte packer.
package cpu_mem_responder_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 128;

  // Loader/responder FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // Byte lane within a 32-bit word; lane 0 is the most significant byte
  typedef logic [1:0] lane_t;

endpackage

// File: rtl/cpu_mem_responder_byte_word_packer.sv
// Packs the loader byte stream big-endian into 32-bit words.
// Latency: word is presented combinationally in the cycle its final byte is accepted.
// Backpressure: none; every accepted byte is absorbed, one per cycle.
//
// Ports:
//   CLK, RST_N      clock, async active-low reset
//   accept          loader byte accepted this cycle (valid & ready)
//   byte_dat        incoming byte
//   last            incoming byte is the final byte of the image
//   word_vld        a complete (or zero-padded final) word is available
//   word_dat        word to write, including the incoming byte
//   word_last       the emitted word ends the image
module byte_word_packer
  import cpu_mem_responder_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              accept,
  input  logic [7:0]        byte_dat,
  input  logic              last,
  output logic              word_vld,
  output logic [DATA_W-1:0] word_dat,
  output logic              word_last
);

  lane_t             lane;
  // Bytes already accepted sit at their final lane positions; lanes not yet
  // filled stay zero, which gives the zero-pad on LD_LAST for free.
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] ins;

  always_comb begin
    ins = '0;
    case (lane)
      2'd0:    ins = {byte_dat, 24'h0};
      2'd1:    ins = {8'h0, byte_dat, 16'h0};
      2'd2:    ins = {16'h0, byte_dat, 8'h0};
      default: ins = {24'h0, byte_dat};
    endcase
  end

  assign word_dat  = acc | ins;
  assign word_vld  = accept & ((lane == 2'd3) | last);
  assign word_last = accept & last;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lane <= '0;
      acc  <= '0;
    end else if (accept) begin
      if (word_vld) begin
        lane <= '0;
        acc  <= '0;
      end else begin
        lane <= lane + 1'b1;
        acc  <= word_dat;
      end
    end
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory responder for the multi-cycle MIPS core with a byte-stream boot loader.
// Latency: reads are combinational (same cycle); writes commit at the CS&WE edge.
// Backpressure: loader is never stalled while loading; LD_READY drops outside LOAD.
//
// Ports:
//   CLK, RST_N          clock, async active-low reset
//   CS, WE, ADDR        CPU chip select, write enable, word address
//   Mem_Bus             shared tri-state data bus (driven here only for RUN reads)
//   LD_VALID/BYTE/LAST  loader byte stream in; LD_READY accepts
//   CPU_HOLD            CPU reset; high until the image is loaded
//   LD_DONE, LD_WORDS   load complete flag and count of words the loader wrote
module cpu_mem_responder #(
  parameter int DEPTH  = cpu_mem_responder_pkg::DEPTH,
  parameter int ADDR_W = cpu_mem_responder_pkg::ADDR_W,
  parameter int DATA_W = cpu_mem_responder_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CS,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] Mem_Bus,
  input  logic              LD_VALID,
  input  logic [7:0]        LD_BYTE,
  input  logic              LD_LAST,
  output logic              LD_READY,
  output logic              CPU_HOLD,
  output logic              LD_DONE,
  output logic [ADDR_W:0]   LD_WORDS
);
  import cpu_mem_responder_pkg::*;

  logic [1:0]        state;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W:0]   ld_words;

  logic              accept;
  logic              word_vld;
  logic              word_last;
  logic [31:0]       word_dat;

  logic              load_wr;
  logic              run_wr;
  logic              run_rd;

  // Not reset: a reset mid-load must leave untouched words intact.
  logic [DATA_W-1:0] mem [DEPTH];

  assign LD_READY = (state == ST_LOAD);
  assign CPU_HOLD = (state != ST_RUN);
  assign LD_DONE  = (state == ST_RUN);
  assign LD_WORDS = ld_words;

  assign accept  = LD_VALID & LD_READY;
  assign load_wr = (state == ST_LOAD) & word_vld;
  assign run_wr  = (state == ST_RUN) & CS & WE;
  assign run_rd  = (state == ST_RUN) & CS & ~WE;

  byte_word_packer u_packer (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .accept    (accept),
    .byte_dat  (LD_BYTE),
    .last      (LD_LAST),
    .word_vld  (word_vld),
    .word_dat  (word_dat),
    .word_last (word_last)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      wptr     <= '0;
      ld_words <= '0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_LOAD;
        ST_LOAD: begin
          if (word_vld) begin
            wptr     <= wptr + 1'b1;
            ld_words <= ld_words + 1'b1;
            // Leave on the final byte, or once the last array word is filled
            if (word_last || (wptr == ADDR_W'(DEPTH - 1)))
              state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (load_wr)
      mem[wptr] <= word_dat;
    else if (run_wr)
      mem[ADDR] <= Mem_Bus;
  end

  // Only RUN reads drive the bus, so the CPU never contends with us
  assign Mem_Bus = run_rd ? mem[ADDR] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: loader streams and CPU bus traffic
// checked against a word-level memory model built from the byte stream.
module tb_cpu_mem_responder;

  typedef logic [7:0] byte_q_t[$];

  logic        clk;
  logic        rst_n;
  logic        cs;
  logic        we;
  logic [6:0]  addr;
  wire  [31:0] mem_bus;
  logic        ld_valid;
  logic [7:0]  ld_byte;
  logic        ld_last;
  logic        ld_ready;
  logic        cpu_hold;
  logic        ld_done;
  logic [7:0]  ld_words;

  logic [31:0] tb_drv;
  logic        tb_drv_en;

  assign mem_bus = tb_drv_en ? tb_drv : 32'hz;

  int n_checks;
  int n_fail;

  logic [31:0] exp_mem [128];

  cpu_mem_responder dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .CS       (cs),
    .WE       (we),
    .ADDR     (addr),
    .Mem_Bus  (mem_bus),
    .LD_VALID (ld_valid),
    .LD_BYTE  (ld_byte),
    .LD_LAST  (ld_last),
    .LD_READY (ld_ready),
    .CPU_HOLD (cpu_hold),
    .LD_DONE  (ld_done),
    .LD_WORDS (ld_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word image a loader stream should leave in memory: big-endian packing,
  // zero-padded final word only when LD_LAST ends the stream, capped at 128 words.
  task automatic model_load(input byte_q_t q, input bit last, output int words);
    int n;
    logic [31:0] w;
    n = q.size();
    if (!last && n > 512) n = 512;
    words = last ? (n + 3) / 4 : n / 4;
    if (words > 128) words = 128;
    for (int i = 0; i < words; i++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++)
        if (4 * i + j < n) w[31 - 8 * j -: 8] = q[4 * i + j];
      exp_mem[i] = w;
    end
  endtask

  task automatic send_stream(input byte_q_t q, input bit last_on_end);
    for (int i = 0; i < q.size(); i++) begin
      ld_valid = 1'b1;
      ld_byte  = q[i];
      ld_last  = last_on_end && (i == q.size() - 1);
      @(posedge clk); #1;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  // Reset pulse; returns one cycle after release, i.e. in LOAD
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic bus_read(input logic [6:0] a, output logic [31:0] d);
    cs = 1'b1; we = 1'b0; addr = a; tb_drv_en = 1'b0;
    @(negedge clk);
    d = mem_bus;
    @(posedge clk); #1;
    cs = 1'b0;
  endtask

  task automatic bus_write(input logic [6:0] a, input logic [31:0] d);
    cs = 1'b1; we = 1'b1; addr = a; tb_drv = d; tb_drv_en = 1'b1;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0; tb_drv_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_checks++;
    if (cpu_hold !== 1'b1 || ld_ready !== 1'b0 || ld_done !== 1'b0 || ld_words !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: hold=%b ready=%b done=%b words=%0d, need 1 0 0 0",
               cpu_hold, ld_ready, ld_done, ld_words);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cpu_hold !== 1'b1 || ld_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_cycle: hold=%b ready=%b, need 1 0", cpu_hold, ld_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (ld_ready !== 1'b1 || cpu_hold !== 1'b1 || ld_done !== 1'b0) begin
      n_fail++;
      $display("FAIL enter_load: ready=%b hold=%b done=%b, need 1 1 0", ld_ready, cpu_hold, ld_done);
    end
    // CPU read attempt during LOAD must leave the bus to whoever drives it
    cs = 1'b1; we = 1'b0; addr = 7'd0; tb_drv = 32'h5A5AC3C3; tb_drv_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_bus !== 32'h5A5AC3C3) begin
      n_fail++;
      $display("FAIL load_bus_hiz: bus=%h, need %h", mem_bus, 32'h5A5AC3C3);
    end
    @(posedge clk); #1;
    cs = 1'b0; tb_drv_en = 1'b0;
  endtask

  task automatic test_load_basic();
    byte_q_t q;
    int words;
    logic [31:0] d;
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    model_load(q, 1'b1, words);
    send_stream(q[0:6], 1'b0);
    n_checks++;
    if (cpu_hold !== 1'b1 || ld_words !== 8'd1) begin
      n_fail++;
      $display("FAIL basic_before_last: hold=%b words=%0d, need 1 1", cpu_hold, ld_words);
    end
    send_stream(q[7:7], 1'b1);
    n_checks++;
    if (cpu_hold !== 1'b0 || ld_done !== 1'b1 || ld_ready !== 1'b0 || ld_words !== 8'(words)) begin
      n_fail++;
      $display("FAIL basic_after_last: hold=%b done=%b ready=%b words=%0d, need 0 1 0 %0d",
               cpu_hold, ld_done, ld_ready, ld_words, words);
    end
    bus_read(7'd0, d);
    n_checks++;
    if (d !== 32'h01020304) begin
      n_fail++;
      $display("FAIL basic_mem0: got %h, need %h", d, 32'h01020304);
    end
    bus_read(7'd1, d);
    n_checks++;
    if (d !== exp_mem[1]) begin
      n_fail++;
      $display("FAIL basic_mem1: got %h, need %h", d, exp_mem[1]);
    end
  endtask

  task automatic test_run_rw();
    logic [31:0] d;
    bus_write(7'd5, 32'hDEADBEEF);
    exp_mem[5] = 32'hDEADBEEF;
    bus_read(7'd5, d);
    n_checks++;
    if (d !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL run_write_read: got %h, need %h", d, 32'hDEADBEEF);
    end
    cs = 1'b0; addr = 7'd5; tb_drv = 32'h12345678; tb_drv_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_bus !== 32'h12345678) begin
      n_fail++;
      $display("FAIL cs0_bus_hiz: bus=%h, need %h", mem_bus, 32'h12345678);
    end
    @(posedge clk); #1;
    tb_drv_en = 1'b0;
    bus_read(7'd5, d);
    n_checks++;
    if (d !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL cs0_no_write: got %h, need %h", d, 32'hDEADBEEF);
    end
  endtask

  task automatic test_pad();
    byte_q_t q;
    int words;
    logic [31:0] d;
    do_reset();
    q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    model_load(q, 1'b1, words);
    send_stream(q, 1'b1);
    n_checks++;
    if (ld_words !== 8'd2 || ld_done !== 1'b1 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL pad_status: words=%0d done=%b hold=%b, need 2 1 0", ld_words, ld_done, cpu_hold);
    end
    bus_read(7'd0, d);
    n_checks++;
    if (d !== exp_mem[0]) begin
      n_fail++;
      $display("FAIL pad_mem0: got %h, need %h", d, exp_mem[0]);
    end
    bus_read(7'd1, d);
    n_checks++;
    if (d !== 32'hEE000000) begin
      n_fail++;
      $display("FAIL pad_mem1: got %h, need %h", d, 32'hEE000000);
    end
  endtask

  task automatic test_full();
    byte_q_t q;
    byte_q_t extra;
    int words;
    int bad;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 512; i++) q.push_back(8'($urandom));
    for (int i = 0; i < 8; i++) extra.push_back(8'($urandom));
    model_load(q, 1'b0, words);
    send_stream(q[0:507], 1'b0);
    n_checks++;
    if (cpu_hold !== 1'b1 || ld_words !== 8'd127) begin
      n_fail++;
      $display("FAIL full_before_end: hold=%b words=%0d, need 1 127", cpu_hold, ld_words);
    end
    send_stream(q[508:511], 1'b0);
    n_checks++;
    if (ld_words !== 8'(words) || ld_ready !== 1'b0 || ld_done !== 1'b1 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL full_status: words=%0d ready=%b done=%b hold=%b, need %0d 0 1 0",
               ld_words, ld_ready, ld_done, cpu_hold, words);
    end
    send_stream(extra, 1'b1);
    n_checks++;
    if (ld_words !== 8'd128) begin
      n_fail++;
      $display("FAIL full_extra_words: words=%0d, need 128", ld_words);
    end
    bad = 0;
    for (int i = 0; i < 128; i++) begin
      bus_read(7'(i), d);
      n_checks++;
      if (d !== exp_mem[i]) begin
        n_fail++;
        bad++;
        if (bad <= 4) $display("FAIL full_mem[%0d]: got %h, need %h", i, d, exp_mem[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    byte_q_t q;
    int words;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    model_load(q, 1'b0, words);
    send_stream(q, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (cpu_hold !== 1'b1 || ld_ready !== 1'b0 || ld_words !== 8'd0) begin
      n_fail++;
      $display("FAIL midreset_async: hold=%b ready=%b words=%0d, need 1 0 0", cpu_hold, ld_ready, ld_words);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    model_load(q, 1'b1, words);
    send_stream(q, 1'b1);
    n_checks++;
    if (ld_words !== 8'd1 || ld_done !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_reload: words=%0d done=%b, need 1 1", ld_words, ld_done);
    end
    bus_read(7'd0, d);
    n_checks++;
    if (d !== 32'h11223344) begin
      n_fail++;
      $display("FAIL midreset_mem0: got %h, need %h", d, 32'h11223344);
    end
    bus_read(7'd1, d);
    n_checks++;
    if (d !== exp_mem[1]) begin
      n_fail++;
      $display("FAIL midreset_mem1_kept: got %h, need %h", d, exp_mem[1]);
    end
  endtask

  task automatic test_random_load();
    byte_q_t q;
    int words;
    int n;
    logic [31:0] d;
    for (int r = 0; r < 3; r++) begin
      q.delete();
      do_reset();
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      model_load(q, 1'b1, words);
      send_stream(q, 1'b1);
      n_checks++;
      if (ld_words !== 8'(words) || ld_done !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_load_words: n=%0d words=%0d done=%b, need %0d 1", n, ld_words, ld_done, words);
      end
      for (int i = 0; i < words; i++) begin
        bus_read(7'(i), d);
        n_checks++;
        if (d !== exp_mem[i]) begin
          n_fail++;
          $display("FAIL rand_load_mem[%0d]: got %h, need %h", i, d, exp_mem[i]);
        end
      end
    end
  endtask

  task automatic test_random_rw();
    logic [6:0]  a;
    logic [31:0] d;
    logic [7:0]  words0;
    words0 = ld_words;
    for (int i = 0; i < 300; i++) begin
      // Loader noise in RUN must have no effect
      ld_valid = 1'($urandom);
      ld_byte  = 8'($urandom);
      ld_last  = 1'($urandom);
      a = 7'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        bus_write(a, d);
        exp_mem[a] = d;
      end else begin
        bus_read(a, d);
        n_checks++;
        if (d !== exp_mem[a]) begin
          n_fail++;
          $display("FAIL rand_rw_read[%0d]: got %h, need %h", a, d, exp_mem[a]);
        end
      end
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    n_checks++;
    if (ld_words !== words0 || ld_ready !== 1'b0 || cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_rw_status: words=%0d ready=%b hold=%b, need %0d 0 0",
               ld_words, ld_ready, cpu_hold, words0);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    cs        = 1'b0;
    we        = 1'b0;
    addr      = '0;
    ld_valid  = 1'b0;
    ld_byte   = '0;
    ld_last   = 1'b0;
    tb_drv    = '0;
    tb_drv_en = 1'b0;
    for (int i = 0; i < 128; i++) exp_mem[i] = 32'h0;

    test_reset();
    test_load_basic();
    test_run_rw();
    test_pad();
    test_full();
    test_mid_reset();
    test_random_load();
    test_random_rw();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
